rvv_xrf_wb_serializer: RTL and testbench
========================================

// Module: rvv_xrf_wb_serializer
// PURPOSE
//  Downstream of the RVV core's scalar-regfile writeback. Collects up to NUM_PORTS
//  in-order retire writebacks (rt_xrf_*) per cycle and buffers them in a FIFO.
//  Drains them one per cycle onto the single async_rd_valid/addr/data/ready port.
//  Replaces the slot-0-only tie-off so no retire lane is dropped or stalled forever.
// PARAMETERS
//  NUM_PORTS  4   retire lanes in; equals `NUM_RT_UOP
//  DEPTH      8   FIFO entries; power of 2, >= NUM_PORTS
//  ADDR_W     5   scalar register index width
//  DATA_W     32  scalar register data width
// PORTS
//  clk        in   1                 core clock, all state on posedge
//  rstn       in   1                 synchronous active-low reset
//  in_valid   in   NUM_PORTS         per-lane writeback valid (rt_xrf_valid_rvv2rvs)
//  in_addr    in   NUM_PORTS*ADDR_W  per-lane rd index (rt_index)
//  in_data    in   NUM_PORTS*DATA_W  per-lane rd data (rt_data)
//  in_ready   out  NUM_PORTS         per-lane accept (rt_xrf_ready_rvs2rvv)
//  out_valid  out  1                 async_rd_valid
//  out_addr   out  ADDR_W            async_rd_addr
//  out_data   out  DATA_W            async_rd_data
//  out_ready  in   1                 async_rd_ready
//  count      out  $clog2(DEPTH)+1   occupied entries
//  idle       out  1                 count==0 && in_valid==0
// BEHAVIOUR
//  - Reset (rstn==0 at posedge): wr_ptr=rd_ptr=count=0; contents discarded.
//    While rstn==0, in_ready=0 and out_valid=0.
//    After reset: out_valid=0, out_addr=0, out_data=0, count=0, in_ready=all 1s.
//  - in_ready[i] = rstn && (DEPTH-count >= i+1). Depends only on registered count,
//    not on in_valid or out_ready, so there is no comb path from out_ready to in_ready.
//  - in_valid is a contiguous prefix from lane 0 (in-order retire).
//    Non-prefix masks are a protocol error, caught by assertion; RTL need not handle them.
//  - Lane i transfers when in_valid[i]&&in_ready[i]. Upstream holds non-accepted
//    lanes stable until accepted.
//  - x0 filter: an accepted lane with addr==0 is consumed but not enqueued.
//  - Enqueue order: surviving accepted lanes, lane 0 first, to consecutive slots
//    from wr_ptr. push_n = number enqueued (0..NUM_PORTS).
//  - Output is first-word-fall-through from the head: out_valid = count!=0,
//    out_addr/out_data = mem[rd_ptr].
//  - Pop when out_valid&&out_ready. Latency from accept to out_valid is 1 cycle;
//    there is no same-cycle bypass.
//  - When out_valid==0, out_addr/out_data drive 0.
//  - out_* stay stable while out_valid&&!out_ready.
//  - count_next = count + push_n - pop. Push and pop may occur in the same cycle.
//    A pop in cycle t frees space visible to in_ready only in t+1.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. A multi-lane push may
//    straddle the wrap point.
//  - Full (count==DEPTH): in_ready=0; a pop still proceeds.
//    Empty: out_valid=0 and out_ready is ignored.
//  - Overflow and underflow are impossible by construction; assertions check
//    count<=DEPTH at all times.
// STRUCTURE
//  - Package rvv_xrf_wb_pkg:
//      typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} xrf_wb_t;
//      localparam XRF_WB_W.
//  - Sub-module rvv_mpush_fifo (DEPTH, NUM_PORTS, type T) holds the storage,
//    pointers and count. It takes a compacted push vector + push_n and a
//    single-pop port.
//  - The top holds the ready generation, the x0 filter/compaction and the output mux.
// TESTING
//  1. Reset: hold rstn=0 2 cycles, then 1 -> out_valid=0, count=0, in_ready=4'b1111.
//  2. Single write: in_valid=0001, addr=5, data=32'hDEAD_BEEF, out_ready=1 -> next cycle
//     out_valid=1, addr=5, data=DEAD_BEEF; the cycle after, count=0 and idle=1.
//  3. Order: out_ready=0, in_valid=1111, addrs 1,2,3,4 -> count=4; then out_ready=1
//     -> out_addr 1,2,3,4 on 4 consecutive cycles.
//  4. Near-full: DEPTH=8, count=7 -> in_ready=0001; in_valid=0011 -> only lane0 taken,
//     count=8, in_ready=0000. With out_ready=1 -> count=7 next cycle, in_ready=0001.
//  5. x0 drop: in_valid=0011, lane0 addr=0, lane1 addr=7 -> both ready, count=1,
//     only addr 7 emerges. Then wrap: repeat 3 pushes of 4 with rd_ptr=6 -> FIFO order kept.
//  6. Reset mid-op: count=5, out_ready=0, rstn=0 one cycle -> out_valid=0, count=0;
//     entries never appear.

Source files
------------

// File: rtl/rvv_xrf_wb_pkg.sv
// Shared types for the scalar-regfile writeback serializer.
// One buffered entry is a destination register index plus its data.
package rvv_xrf_wb_pkg;

  localparam int XRF_ADDR_W = 5;
  localparam int XRF_DATA_W = 32;

  typedef struct packed {
    logic [XRF_ADDR_W-1:0] addr;
    logic [XRF_DATA_W-1:0] data;
  } xrf_wb_t;

  localparam int XRF_WB_W = $bits(xrf_wb_t);

endpackage

// File: rtl/rvv_mpush_fifo.sv
// Circular FIFO that accepts up to NUM_PORTS compacted entries per cycle
// and releases one entry per cycle from a fall-through head.
module rvv_mpush_fifo #(
  parameter int  DEPTH     = 8,
  parameter int  NUM_PORTS = 4,
  parameter type T         = logic,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1,
  localparam int PN_W      = $clog2(NUM_PORTS + 1)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  T     [NUM_PORTS-1:0]      push_data,
  input  logic [PN_W-1:0]           push_n,
  input  logic                      pop,
  output T                          head,
  output logic [CNT_W-1:0]          count
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] slot [NUM_PORTS];

  // Slot indices wrap naturally, so a multi-entry push may straddle the end.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      slot[i] = wr_ptr_q + PTR_W'(i);
    end
    wr_ptr_d = wr_ptr_q + PTR_W'(push_n);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push_n) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is meaningful.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (PN_W'(i) < push_n) begin
        mem_q[slot[i]] <= push_data[i];
      end
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/rvv_xrf_wb_serializer.sv
// Collects in-order retire writebacks from several lanes per cycle and
// drains them one per cycle onto the single scalar-regfile write port.
module rvv_xrf_wb_serializer
  import rvv_xrf_wb_pkg::*;
#(
  parameter int  NUM_PORTS = 4,
  parameter int  DEPTH     = 8,
  parameter int  ADDR_W    = XRF_ADDR_W,
  parameter int  DATA_W    = XRF_DATA_W,
  localparam int CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0] in_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  output logic [NUM_PORTS-1:0]        in_ready,
  output logic                        out_valid,
  output logic [ADDR_W-1:0]           out_addr,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [CNT_W-1:0]            count,
  output logic                        idle
);

  localparam int PN_W = $clog2(NUM_PORTS + 1);
  localparam logic [NUM_PORTS-1:0] LANE_ONE = {{(NUM_PORTS-1){1'b0}}, 1'b1};

  xrf_wb_t [NUM_PORTS-1:0] push_vec;
  logic [PN_W-1:0]         push_n;
  logic                    pop;
  xrf_wb_t                 head;
  logic [CNT_W-1:0]        free;

  // Readiness looks only at registered occupancy, keeping out_ready off this path.
  always_comb begin
    free = CNT_W'(DEPTH) - count;
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = rstn && (free > CNT_W'(i));
    end
  end

  // Accepted lanes writing x0 are consumed but leave a gap that is squeezed out.
  always_comb begin
    int rank;
    push_vec = '0;
    rank     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && in_ready[i] && (in_addr[i*ADDR_W +: ADDR_W] != '0)) begin
        for (int j = 0; j < NUM_PORTS; j++) begin
          if (j == rank) begin
            push_vec[j].addr = in_addr[i*ADDR_W +: ADDR_W];
            push_vec[j].data = in_data[i*DATA_W +: DATA_W];
          end
        end
        rank++;
      end
    end
    push_n = PN_W'(rank);
  end

  rvv_mpush_fifo #(
    .DEPTH     (DEPTH),
    .NUM_PORTS (NUM_PORTS),
    .T         (xrf_wb_t)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_data (push_vec),
    .push_n    (push_n),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_comb begin
    out_valid = rstn && (count != '0);
    out_addr  = '0;
    out_data  = '0;
    if (out_valid) begin
      out_addr = head.addr;
      out_data = head.data;
    end
  end

  assign pop  = out_valid && out_ready;
  assign idle = (count == '0) && (in_valid == '0);

  a_count_bound: assert property (@(posedge clk) disable iff (!rstn)
    count <= CNT_W'(DEPTH));

  a_valid_prefix: assert property (@(posedge clk) disable iff (!rstn)
    (in_valid & (in_valid + LANE_ONE)) == '0);

endmodule

// File: tb/tb_rvv_xrf_wb_serializer.sv
// Randomized scoreboard bench for the writeback serializer; the model is a
// plain queue of expected register writes plus an upstream retire queue.
module tb_rvv_xrf_wb_serializer;

  localparam int NP    = 4;
  localparam int DEPTH = 8;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [NP-1:0]     in_valid = '0;
  logic [NP*AW-1:0]  in_addr = '0;
  logic [NP*DW-1:0]  in_data = '0;
  logic [NP-1:0]     in_ready;
  logic              out_valid;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_data;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     count;
  logic              idle;

  always #5 clk = ~clk;

  rvv_xrf_wb_serializer #(
    .NUM_PORTS (NP),
    .DEPTH     (DEPTH),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_ready (out_ready),
    .count     (count),
    .idle      (idle)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } item_t;

  item_t exp_q[$];   // register writes the DUT holds right now, oldest first
  item_t pend_q[$];  // accepted this cycle, visible to the output next cycle
  item_t up_q[$];    // upstream retire stream not yet accepted

  int n_cmp = 0;
  int n_bad = 0;
  int arr_pct  = 0;
  int ordy_pct = 100;
  int zero_pct = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] rdy_mask(input int occ);
    logic [NP-1:0] m;
    m = '0;
    for (int i = 0; i < NP; i++) m[i] = ((DEPTH - occ) >= (i + 1));
    return m;
  endfunction

  // Monitor: compares the DUT against the model on the falling edge.
  int  mon_occ;
  bit  mon_ev;
  initial begin
    forever begin
      @(negedge clk);
      mon_occ = exp_q.size();
      mon_ev  = rstn && (mon_occ != 0);
      chk("in_ready", 64'(in_ready), rstn ? 64'(rdy_mask(mon_occ)) : 64'd0);
      chk("out_valid", 64'(out_valid), 64'(mon_ev));
      if (rstn) begin
        chk("count", 64'(count), 64'(mon_occ));
        chk("idle", 64'(idle), 64'((mon_occ == 0) && (in_valid == '0)));
      end
      if (mon_ev) begin
        chk("out_addr", 64'(out_addr), 64'(exp_q[0].a));
        chk("out_data", 64'(out_data), 64'(exp_q[0].d));
        if (out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_addr_idle", 64'(out_addr), 64'd0);
        chk("out_data_idle", 64'(out_data), 64'd0);
      end
    end
  end

  task automatic inject(input logic [AW-1:0] a, input logic [DW-1:0] d);
    item_t it;
    it.a = a;
    it.d = d;
    up_q.push_back(it);
  endtask

  // One clock of stimulus, driven just after the rising edge.
  task automatic cycle(input bit rst);
    int k;
    int nrdy;
    int acc;
    int nnew;
    item_t it;
    @(posedge clk);
    #1;
    foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
    pend_q.delete();
    if (rst) begin
      rstn = 1'b0;
      exp_q.delete();
      up_q.delete();
      in_valid  = '0;
      out_ready = 1'($urandom_range(0, 1));
      return;
    end
    rstn = 1'b1;
    if (($urandom_range(0, 99) < arr_pct) && (up_q.size() < 12)) begin
      nnew = $urandom_range(1, NP);
      for (int n = 0; n < nnew; n++) begin
        it.a = ($urandom_range(0, 99) < zero_pct) ? '0 : AW'($urandom_range(1, 31));
        it.d = $urandom;
        up_q.push_back(it);
      end
    end
    k = (up_q.size() < NP) ? up_q.size() : NP;
    in_valid = '0;
    for (int i = 0; i < NP; i++) begin
      in_addr[i*AW +: AW] = AW'($urandom);
      in_data[i*DW +: DW] = $urandom;
    end
    for (int i = 0; i < k; i++) begin
      in_valid[i]         = 1'b1;
      in_addr[i*AW +: AW] = up_q[i].a;
      in_data[i*DW +: DW] = up_q[i].d;
    end
    nrdy = DEPTH - exp_q.size();
    if (nrdy > NP) nrdy = NP;
    acc = (k < nrdy) ? k : nrdy;
    for (int i = 0; i < acc; i++) begin
      if (up_q[0].a != '0) pend_q.push_back(up_q[0]);
      void'(up_q.pop_front());
    end
    out_ready = ($urandom_range(0, 99) < ordy_pct);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    cycle(1'b1);
    cycle(1'b1);
    arr_pct  = 0;
    ordy_pct = 100;
    run(2);

    // single write
    inject(5'd5, 32'hDEAD_BEEF);
    run(4);

    // ordering with the output stalled, then drained
    ordy_pct = 0;
    for (int i = 1; i <= 4; i++) inject(AW'(i), 32'h1000_0000 + DW'(i));
    run(3);
    ordy_pct = 100;
    run(6);

    // near-full and full
    ordy_pct = 0;
    for (int i = 0; i < 7; i++) inject(AW'(10 + i), $urandom);
    run(2);
    inject(5'd20, 32'hAAAA_0001);
    inject(5'd21, 32'hAAAA_0002);
    run(3);
    ordy_pct = 100;
    run(12);

    // x0 filter
    inject(5'd0, 32'h0BAD_0BAD);
    inject(5'd7, 32'h7777_7777);
    run(4);

    // reset in mid-operation
    ordy_pct = 0;
    for (int i = 0; i < 5; i++) inject(AW'(i + 1), $urandom);
    run(3);
    cycle(1'b1);
    ordy_pct = 100;
    run(4);

    // randomized traffic, including occasional resets and x0 writes
    for (int blk = 0; blk < 24; blk++) begin
      arr_pct  = $urandom_range(20, 100);
      ordy_pct = $urandom_range(10, 100);
      zero_pct = $urandom_range(0, 30);
      run(100);
      if (blk % 8 == 7) cycle(1'b1);
    end
    arr_pct  = 0;
    ordy_pct = 100;
    run(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
